coherent_dcache: RTL and testbench

- Per-core direct-mapped, write-back L1 data cache with MSI coherence.
- Sits between one CPU datapath and one slice of the dual-core bus/memory controller: it issues block fills and writebacks and answers snoops from the other core.
- One instance per core; the two instances connect to index [0] and [1] of the controller's cache_control_if arrays.

---
 rtl/coherent_dcache.sv | 203 ++++++++++++++++++++
 tb/tb_coherent_dcache.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_dcache.sv
// Direct-mapped write-back L1 data cache with MSI snooping for one core of a dual-core system.
// One FSM handles misses, victim writebacks, snoop supplies and the halt-time flush.
module coherent_dcache #(
  parameter int SETS = 8,
  parameter int BLKW = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);
  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(BLKW);
  localparam int TW = 32 - IW - OW - 2;
  localparam logic [IW-1:0] LAST = IW'(SETS - 1);

  typedef enum logic [1:0] {INV, SHR, MOD} line_t;
  typedef enum logic [3:0] {
    IDLE, WB1, WB2, ALLOC, LD1, LD2, SNOOP, SNWB1, SNWB2, FLUSH, FWB1, FWB2, HALTED
  } state_t;

  state_t        state, ret;
  line_t         lstate [SETS];
  logic [TW-1:0] tags   [SETS];
  logic [31:0]   word0  [SETS];
  logic [31:0]   word1  [SETS];
  logic [31:0]   fill0;
  logic [IW-1:0] fidx, sn_idx;
  logic          sn_inv;

  logic [TW-1:0] rtag, stag;
  logic [IW-1:0] idx, sidx;
  logic          off, valid, ld_hit, st_hit, miss, s_match, s_mod;
  logic          unused_bits;

  assign rtag        = dmemaddr[31:IW+OW+2];
  assign idx         = dmemaddr[IW+OW+1:OW+2];
  assign off         = dmemaddr[2];
  assign stag        = ccsnoopaddr[31:IW+OW+2];
  assign sidx        = ccsnoopaddr[IW+OW+1:OW+2];
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};

  assign valid    = (lstate[idx] != INV) && (tags[idx] == rtag);
  assign ld_hit   = (state == IDLE) && !ccwait && dmemREN && valid;
  assign st_hit   = (state == IDLE) && !ccwait && dmemWEN && valid && (lstate[idx] == MOD);
  assign miss     = (dmemREN || dmemWEN) && !ld_hit && !st_hit;
  assign dhit     = ld_hit || st_hit;
  assign dmemload = ld_hit ? (off ? word1[idx] : word0[idx]) : '0;
  assign s_match  = (lstate[sidx] != INV) && (tags[sidx] == stag);
  assign s_mod    = s_match && (lstate[sidx] == MOD);

  function automatic logic [31:0] blk_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                           input logic w);
    return {t, i, w, 2'b00};
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ret     <= IDLE;
      fidx    <= '0;
      sn_idx  <= '0;
      sn_inv  <= 1'b0;
      flushed <= 1'b0;
      for (int i = 0; i < SETS; i++) lstate[i] <= INV;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            state <= SNOOP;
            ret   <= IDLE;
          end else if (halt) state <= FLUSH;
          else if (miss) state <= (lstate[idx] == MOD) ? WB1 : ALLOC;
        end
        WB1: if (!dwait) state <= WB2;
        WB2: if (!dwait) begin
          lstate[idx] <= INV;
          state       <= ALLOC;
        end
        // A snoop arriving while we wait for the bus is answered first so two missing cores never deadlock.
        ALLOC: begin
          if (ccwait) begin
            state <= SNOOP;
            ret   <= ALLOC;
          end else if (!dwait) state <= LD1;
        end
        LD1: if (!dwait) state <= LD2;
        LD2: if (!dwait) begin
          lstate[idx] <= dmemWEN ? MOD : SHR;
          state       <= IDLE;
        end
        SNOOP: begin
          sn_idx <= sidx;
          sn_inv <= ccinv;
          if (s_mod) state <= SNWB1;
          else begin
            if (ccinv && s_match) lstate[sidx] <= INV;
            state <= ret;
          end
        end
        SNWB1: if (!dwait) state <= SNWB2;
        SNWB2: if (!dwait) begin
          lstate[sn_idx] <= sn_inv ? INV : SHR;
          state          <= ret;
        end
        // Each index is visited once; a dirty line detours through FWB and comes back clean.
        FLUSH: begin
          if (lstate[fidx] == MOD) state <= FWB1;
          else begin
            lstate[fidx] <= INV;
            if (fidx == LAST) begin
              state   <= HALTED;
              flushed <= 1'b1;
            end else fidx <= fidx + IW'(1);
          end
        end
        FWB1: if (!dwait) state <= FWB2;
        FWB2: if (!dwait) begin
          lstate[fidx] <= INV;
          state        <= FLUSH;
        end
        HALTED: begin
          if (ccwait) begin
            state <= SNOOP;
            ret   <= HALTED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (st_hit) begin
      if (off) word1[idx] <= dmemstore;
      else     word0[idx] <= dmemstore;
    end
    if (state == LD1 && !dwait) fill0 <= dload;
    if (state == LD2 && !dwait) begin
      word0[idx] <= fill0;
      word1[idx] <= dload;
      tags[idx]  <= rtag;
    end
  end

  always_comb begin
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = '0;
    dstore  = '0;
    cctrans = 1'b0;
    ccwrite = 1'b0;
    case (state)
      WB1, WB2: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tags[idx], idx, state == WB2);
        dstore = (state == WB2) ? word1[idx] : word0[idx];
      end
      ALLOC: begin
        cctrans = 1'b1;
        dREN    = 1'b1;
        ccwrite = dmemWEN;
        daddr   = blk_addr(rtag, idx, 1'b0);
      end
      LD1, LD2: begin
        dREN  = 1'b1;
        daddr = blk_addr(rtag, idx, state == LD2);
      end
      SNOOP: begin
        cctrans = 1'b1;
        ccwrite = s_mod;
      end
      SNWB1, SNWB2: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tags[sn_idx], sn_idx, state == SNWB2);
        dstore = (state == SNWB2) ? word1[sn_idx] : word0[sn_idx];
      end
      FWB1, FWB2: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tags[fidx], fidx, state == FWB2);
        dstore = (state == FWB2) ? word1[fidx] : word0[fidx];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherent_dcache.sv
// Bench for coherent_dcache: plays bus controller and peer core, and compares every transaction
// against a line-level MSI model plus a flat image of the values the program last stored.
module tb_coherent_dcache;
  localparam int SETS = 8;
  localparam int INV = 0, SHR = 1, MOD = 2;

  logic        CLK = 1'b0;
  logic        nRST, dmemREN, dmemWEN, halt, dwait, ccwait, ccinv;
  logic [31:0] dmemaddr, dmemstore, dload, ccsnoopaddr;
  logic        dhit, flushed, dREN, dWEN, cctrans, ccwrite;
  logic [31:0] dmemload, daddr, dstore;

  coherent_dcache #(.SETS(SETS), .BLKW(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          m_st    [SETS];
  logic [31:0] m_tag   [SETS];
  logic [63:0] wq[$], ewq[$];
  logic [31:0] rq[$], erq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic int set_of(input logic [31:0] a);
    return int'((a / 8) % SETS);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (8 * SETS);
  endfunction
  function automatic logic [31:0] base_of(input logic [31:0] a);
    return (a / 8) * 8;
  endfunction

  // Bus side of the controller: random wait states, memory reads and writes, transfer logging.
  task automatic serve();
    dwait = ($urandom_range(0, 3) == 0);
    dload = dREN ? mem_rd(daddr) : $urandom;
    if (dWEN && !dwait) begin
      wq.push_back({daddr, dstore});
      mem[daddr] = dstore;
    end
    if (dREN && !cctrans && !dwait) rq.push_back(daddr);
  endtask

  task automatic clear_q();
    wq.delete(); ewq.delete(); rq.delete(); erq.delete();
  endtask

  task automatic cmp_bus(input string tag);
    chk({tag, "_nwrites"}, wq.size(), ewq.size());
    for (int i = 0; i < ewq.size() && i < wq.size(); i++) chk({tag, "_write"}, wq[i], ewq[i]);
    chk({tag, "_nreads"}, rq.size(), erq.size());
    for (int i = 0; i < erq.size() && i < rq.size(); i++) chk({tag, "_read"}, rq[i], erq[i]);
  endtask

  task automatic push_block(input logic [31:0] b);
    ewq.push_back({b, ref_rd(b)});
    ewq.push_back({b + 32'd4, ref_rd(b + 32'd4)});
  endtask

  task automatic snoop_model(input logic [31:0] sa, input bit inv);
    int s;
    bit match, dirty;
    s     = set_of(sa);
    match = (m_st[s] != INV) && (m_tag[s] == tag_of(sa));
    dirty = match && (m_st[s] == MOD);
    chk("snoop_ccwrite", ccwrite, dirty);
    if (dirty) begin
      push_block(base_of(sa));
      m_st[s] = inv ? INV : SHR;
    end else if (match && inv) m_st[s] = INV;
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit inj, input logic [31:0] sa, input bit sinv);
    int s, cyc;
    bit hit_exp, done, seen_alloc, inj_done;
    logic [31:0] vb;
    clear_q();
    s       = set_of(a);
    hit_exp = (m_st[s] != INV) && (m_tag[s] == tag_of(a)) && (!wr || m_st[s] == MOD);
    if (!hit_exp) begin
      erq.push_back(base_of(a));
      erq.push_back(base_of(a) + 32'd4);
      if (m_st[s] == MOD) begin
        vb = (m_tag[s] * SETS + s) * 8;
        push_block(vb);
        m_st[s] = INV;
      end
    end
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    cyc = 0; done = 0; seen_alloc = 0; inj_done = 0;
    while (!done && cyc < 400) begin
      #1;
      serve();
      if (cctrans && dREN) begin
        if (!seen_alloc) begin
          chk("alloc_ccwrite", ccwrite, wr);
          chk("alloc_addr", daddr, base_of(a));
        end
        seen_alloc = 1;
        if (inj && !inj_done) begin
          ccwait = 1; ccsnoopaddr = sa; ccinv = sinv; inj_done = 1;
        end
      end else if (cctrans && ccwait) begin
        ccwait = 0;
        snoop_model(sa, sinv);
      end
      if (dhit) begin
        done = 1;
        if (!wr) chk("load_data", dmemload, ref_rd(a));
      end
      @(negedge CLK);
      cyc++;
    end
    dmemREN = 0; dmemWEN = 0; ccinv = 0;
    chk("access_done", done, 1);
    chk("first_cycle_hit", (cyc == 1), hit_exp);
    cmp_bus("access");
    if (wr) begin
      ref_mem[a] = d;
      m_st[s] = MOD;
      m_tag[s] = tag_of(a);
    end else if (!hit_exp) begin
      m_st[s] = SHR;
      m_tag[s] = tag_of(a);
    end
  endtask

  task automatic snoop(input logic [31:0] sa, input bit inv);
    int cyc;
    bit seen, done;
    clear_q();
    ccwait = 1; ccsnoopaddr = sa; ccinv = inv;
    cyc = 0; seen = 0; done = 0;
    while (!done && cyc < 300) begin
      #1;
      serve();
      if (cctrans && !dREN && !seen) begin
        ccwait = 0;
        snoop_model(sa, inv);
        seen = 1;
      end else if (seen && !dWEN) done = 1;
      @(negedge CLK);
      cyc++;
    end
    ccwait = 0; ccinv = 0;
    chk("snoop_done", done, 1);
    cmp_bus("snoop");
  endtask

  task automatic mid_reset(input logic [31:0] a);
    dmemREN = 1; dmemWEN = 0; dmemaddr = a;
    for (int i = 0; i < 4; i++) begin
      #1;
      serve();
      @(negedge CLK);
    end
    #1 nRST = 0;
    #1;
    chk("rst_dREN", dREN, 0);
    chk("rst_dWEN", dWEN, 0);
    chk("rst_cctrans", cctrans, 0);
    chk("rst_dhit", dhit, 0);
    dmemREN = 0;
    for (int s = 0; s < SETS; s++) m_st[s] = INV;
    ref_mem = mem;
    @(negedge CLK);
    nRST = 1;
    @(negedge CLK);
  endtask

  task automatic do_flush();
    int cyc;
    bit done;
    clear_q();
    for (int s = 0; s < SETS; s++) begin
      if (m_st[s] == MOD) push_block((m_tag[s] * SETS + s) * 8);
      m_st[s] = INV;
    end
    halt = 1;
    cyc = 0; done = 0;
    while (!done && cyc < 600) begin
      #1;
      serve();
      if (flushed) done = 1;
      @(negedge CLK);
      cyc++;
    end
    chk("flush_done", done, 1);
    chk("flush_nwrites_two_lines", wq.size(), 4);
    cmp_bus("flush");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, sa;
    int r;
    nRST = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0; halt = 0;
    dwait = 1; dload = 0; ccwait = 0; ccinv = 0; ccsnoopaddr = 0;
    for (int s = 0; s < SETS; s++) begin
      m_st[s] = INV;
      m_tag[s] = 0;
    end
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_dhit", dhit, 0);
    chk("reset_dREN", dREN, 0);
    chk("reset_dWEN", dWEN, 0);
    chk("reset_cctrans", cctrans, 0);
    chk("reset_ccwrite", ccwrite, 0);
    chk("reset_flushed", flushed, 0);
    chk("reset_daddr", daddr, 0);
    @(negedge CLK);
    nRST = 1;
    @(negedge CLK);

    access(0, 32'h100, 0, 0, 0, 0);
    access(1, 32'h100, 32'hDEAD, 0, 0, 0);
    access(0, 32'h100, 0, 0, 0, 0);
    access(0, 32'h140, 0, 0, 0, 0);
    access(1, 32'h100, 32'hBEEF, 0, 0, 0);
    snoop(32'h100, 0);
    access(0, 32'h104, 0, 0, 0, 0);
    access(1, 32'h104, 32'hCAFE, 0, 0, 0);
    snoop(32'h100, 1);
    access(0, 32'h100, 0, 0, 0, 0);
    access(0, 32'h148, 0, 1, 32'h1C0, 0);
    access(1, 32'h150, 32'h1234, 0, 0, 0);
    access(0, 32'h158, 0, 1, 32'h150, 1);
    access(0, 32'h150, 0, 0, 0, 0);

    for (int n = 0; n < 160; n++) begin
      a  = 32'h100 + 4 * $urandom_range(0, 63);
      sa = 32'h100 + 4 * $urandom_range(0, 63);
      r  = $urandom_range(0, 9);
      if (r < 7) access(r < 3, a, $urandom, $urandom_range(0, 3) == 0, sa, $urandom_range(0, 1) == 1);
      else snoop(a, $urandom_range(0, 1) == 1);
    end

    mid_reset(32'h1A8);
    access(0, 32'h1A8, 0, 0, 0, 0);
    access(1, 32'h100, 32'h0A0A, 0, 0, 0);
    access(1, 32'h12C, 32'h0B0B, 0, 0, 0);
    access(0, 32'h110, 0, 0, 0, 0);
    do_flush();
    snoop(32'h100, 0);
    snoop(32'h128, 1);

    dmemREN = 1; dmemaddr = 32'h110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halted_dhit", dhit, 0);
      chk("halted_dREN", dREN, 0);
      @(negedge CLK);
    end
    dmemREN = 0;
    chk("flushed_sticky", flushed, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
